// File: rtl/gpio_bank_if.sv
// Bus side of gpio_bank: a valid request that completes with a one-cycle ready pulse.
interface gpio_bank_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/gpio_bank.sv
// GPIO bank: direction/output registers, synchronised inputs, optional edge interrupts.
// Edge interrupts (RISE_EN/FALL_EN/STATUS, irq) are built only when GPIO_BANK_IRQ_EN is defined.
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    gpio_bank_if.slave       bus,
    output logic [WIDTH-1:0] io_iosel,
    output logic [WIDTH-1:0] io_out,
    input  logic [WIDTH-1:0] io_in,
    output logic             irq
);
    typedef enum logic [2:0] {
        REG_DIR     = 3'd0,
        REG_OUT     = 3'd1,
        REG_IN      = 3'd2,
        REG_OUT_SET = 3'd3,
        REG_OUT_CLR = 3'd4,
        REG_RISE_EN = 3'd5,
        REG_FALL_EN = 3'd6,
        REG_STATUS  = 3'd7
    } reg_sel_e;

    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] rd_bits;
    logic [31:0]      rd_word;
    logic             accept;
    logic             wr_en;
    reg_sel_e         sel;
    logic             unused_bits;

    // An access is taken only while ready is low, so back-to-back requests take two cycles.
    assign accept  = bus.valid && !bus.ready;
    assign wr_en   = accept && (bus.wstrb != 4'b0000);
    assign sel     = reg_sel_e'(bus.addr[4:2]);
    assign in_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            wmask[i] = bus.wstrb[i >> 3];
        end
    end

    assign wbits = bus.wdata[WIDTH-1:0] & wmask;

`ifdef GPIO_BANK_IRQ_EN
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] status_clr;

    assign edge_set   = (in_sync & ~hist_q & rise_en_q) | (~in_sync & hist_q & fall_en_q);
    assign status_clr = (wr_en && sel == REG_STATUS) ? wbits : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            hist_q    <= '0;
        end else begin
            hist_q   <= in_sync;
            // Clear first, then OR in new edges so a coincident edge is never lost.
            status_q <= (status_q & ~status_clr) | edge_set;
            if (wr_en && sel == REG_RISE_EN) rise_en_q <= (rise_en_q & ~wmask) | wbits;
            if (wr_en && sel == REG_FALL_EN) fall_en_q <= (fall_en_q & ~wmask) | wbits;
        end
    end

    assign irq = |status_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_bits = '0;
        case (sel)
            REG_DIR:     rd_bits = dir_q;
            REG_OUT:     rd_bits = out_q;
            REG_IN:      rd_bits = in_sync;
`ifdef GPIO_BANK_IRQ_EN
            REG_RISE_EN: rd_bits = rise_en_q;
            REG_FALL_EN: rd_bits = fall_en_q;
            REG_STATUS:  rd_bits = status_q;
`endif
            default:     rd_bits = '0;
        endcase
        rd_word = '0;
        rd_word[WIDTH-1:0] = rd_bits;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
            dir_q     <= '0;
            out_q     <= '0;
        end else begin
            bus.ready <= accept;
            if (accept) bus.rdata <= rd_word;
            if (wr_en) begin
                case (sel)
                    REG_DIR:     dir_q <= (dir_q & ~wmask) | wbits;
                    REG_OUT:     out_q <= (out_q & ~wmask) | wbits;
                    REG_OUT_SET: out_q <= out_q | wbits;
                    REG_OUT_CLR: out_q <= out_q & ~wbits;
                    default:     ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= io_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign io_iosel = dir_q;
    assign io_out   = out_q;

    assign unused_bits = ^{bus.addr[31:5], bus.addr[1:0], bus.wdata, bus.wstrb};
endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: vector table, hand-written corner sequences, random vs. model.
module tb_gpio_bank;
    localparam int W = 8;
    localparam int S = 2;
`ifdef GPIO_BANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn;
    logic [W-1:0] io_iosel;
    logic [W-1:0] io_out;
    logic [W-1:0] io_in;
    logic         irq;
    logic [31:0]  rd;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    gpio_bank_if bus ();

    gpio_bank #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .io_iosel (io_iosel),
        .io_out   (io_out),
        .io_in    (io_in),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model state, updated once per rising edge from the applied inputs.
    logic [W-1:0] m_dir, m_out, m_rise, m_fall, m_status;
    logic         m_ready;
    logic [31:0]  m_rdata;
    logic [W-1:0] pin_hist [$];   // pin_hist[j] = io_in sampled j+1 edges ago

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic [W-1:0] exp_iosel;
        logic [W-1:0] exp_out;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] strobe_bits(input logic [3:0] strb);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = strb[i / 8];
        return m;
    endfunction

    task automatic model_reset();
        m_dir = '0; m_out = '0; m_rise = '0; m_fall = '0; m_status = '0;
        m_ready = 1'b0; m_rdata = '0;
        pin_hist.delete();
        for (int i = 0; i <= S; i++) pin_hist.push_back('0);
    endtask

    task automatic model_step();
        logic [W-1:0] cur, prev, set, mask, wd;
        logic [2:0]   a;
        bit           acc;
        cur  = pin_hist[S-1];
        prev = pin_hist[S];
        set  = IRQ_EN ? ((cur & ~prev & m_rise) | (~cur & prev & m_fall)) : '0;
        acc  = bus.valid && !m_ready;
        a    = bus.addr[4:2];
        mask = strobe_bits(bus.wstrb);
        wd   = bus.wdata[W-1:0] & mask;
        if (acc) begin
            m_rdata = '0;
            case (a)
                3'd0: m_rdata[W-1:0] = m_dir;
                3'd1: m_rdata[W-1:0] = m_out;
                3'd2: m_rdata[W-1:0] = cur;
                3'd5: m_rdata[W-1:0] = IRQ_EN ? m_rise : '0;
                3'd6: m_rdata[W-1:0] = IRQ_EN ? m_fall : '0;
                3'd7: m_rdata[W-1:0] = IRQ_EN ? m_status : '0;
                default: ;
            endcase
            if (bus.wstrb != 4'b0) begin
                case (a)
                    3'd0: m_dir = (m_dir & ~mask) | wd;
                    3'd1: m_out = (m_out & ~mask) | wd;
                    3'd3: m_out = m_out | wd;
                    3'd4: m_out = m_out & ~wd;
                    3'd5: if (IRQ_EN) m_rise = (m_rise & ~mask) | wd;
                    3'd6: if (IRQ_EN) m_fall = (m_fall & ~mask) | wd;
                    3'd7: if (IRQ_EN) m_status = m_status & ~wd;
                    default: ;
                endcase
            end
        end
        m_status = m_status | set;
        m_ready  = acc;
        pin_hist.push_front(io_in);
        void'(pin_hist.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_model();
        check("ready", bus.ready, m_ready);
        if (m_ready) check("rdata", bus.rdata, m_rdata);
        check("io_iosel", io_iosel, m_dir);
        check("io_out", io_out, m_out);
        check("irq", irq, |m_status);
    endtask

    task automatic access(input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wd, output logic [31:0] rdv);
        bus.valid = 1'b1;
        bus.addr  = addr;
        bus.wstrb = strb;
        bus.wdata = wd;
        tick();
        bus.valid = 1'b0;
        bus.wstrb = 4'b0;
        rdv = bus.rdata;
        check("ready_pulse", bus.ready, 1'b1);
        tick();
        check("ready_drop", bus.ready, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        bus.valid = 1'b0; bus.addr = '0; bus.wstrb = '0; bus.wdata = '0;
        io_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_ready", bus.ready, 1'b0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_iosel", io_iosel, 8'h00);
        check("rst_out", io_out, 8'h00);
        check("rst_irq", irq, 1'b0);
        resetn = 1'b1;

        // addr, strb, wdata, chk_rd, exp_rd, exp_iosel, exp_out
        tbl.push_back('{32'h00, 4'h1, 32'h000000A5, 1'b0, 32'h0,  8'hA5, 8'h00});
        tbl.push_back('{32'h00, 4'h0, 32'h0,        1'b1, 32'hA5, 8'hA5, 8'h00});
        tbl.push_back('{32'h04, 4'h1, 32'h0000000F, 1'b0, 32'h0,  8'hA5, 8'h0F});
        tbl.push_back('{32'h0C, 4'h1, 32'h000000F0, 1'b0, 32'h0,  8'hA5, 8'hFF});
        tbl.push_back('{32'h10, 4'h1, 32'h00000003, 1'b0, 32'h0,  8'hA5, 8'hFC});
        tbl.push_back('{32'h0C, 4'h0, 32'h0,        1'b1, 32'h0,  8'hA5, 8'hFC});
        tbl.push_back('{32'h10, 4'h0, 32'h0,        1'b1, 32'h0,  8'hA5, 8'hFC});
        tbl.push_back('{32'h04, 4'h0, 32'h0,        1'b1, 32'hFC, 8'hA5, 8'hFC});
        tbl.push_back('{32'h00, 4'h1, 32'hFFFFFF00, 1'b0, 32'h0,  8'h00, 8'hFC});
        tbl.push_back('{32'h00, 4'hE, 32'h12345678, 1'b0, 32'h0,  8'h00, 8'hFC});
        tbl.push_back('{32'h00, 4'hF, 32'h0000003C, 1'b0, 32'h0,  8'h3C, 8'hFC});
        tbl.push_back('{32'h08, 4'hF, 32'h000000FF, 1'b0, 32'h0,  8'h3C, 8'hFC});
        tbl.push_back('{32'h08, 4'h0, 32'h0,        1'b1, 32'h0,  8'h3C, 8'hFC});
        tbl.push_back('{32'h20, 4'h0, 32'h0,        1'b1, 32'h3C, 8'h3C, 8'hFC});
        tbl.push_back('{32'h1C, 4'h0, 32'h0,        1'b1, 32'h0,  8'h3C, 8'hFC});
        tbl.push_back('{32'h14, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0,  8'h3C, 8'hFC});
        tbl.push_back('{32'h14, 4'h0, 32'h0,        1'b1, IRQ_EN ? 32'hFF : 32'h0, 8'h3C, 8'hFC});
        tbl.push_back('{32'h14, 4'hF, 32'h0,        1'b0, 32'h0,  8'h3C, 8'hFC});

        foreach (tbl[i]) begin
            access(tbl[i].addr, tbl[i].strb, tbl[i].wdata, rd);
            if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("tbl%0d_iosel", i), io_iosel, tbl[i].exp_iosel);
            check($sformatf("tbl%0d_out", i), io_out, tbl[i].exp_out);
        end

        // Input synchroniser latency
        io_in = 8'h04;
        tick();
        access(32'h08, 4'h0, 32'h0, rd);
        check("in_early", rd, 32'h0);
        access(32'h08, 4'h0, 32'h0, rd);
        check("in_late", rd, 32'h04);
        io_in = 8'h00;
        repeat (4) tick();

        // Rising edge sets STATUS, W1C clears it, masked falling edge is ignored
        access(32'h14, 4'h1, 32'h01, rd);
        io_in = 8'h01;
        repeat (3) tick();
        check("irq_rise", irq, IRQ_EN);
        access(32'h1C, 4'h0, 32'h0, rd);
        check("status_rise", rd, IRQ_EN ? 32'h1 : 32'h0);
        access(32'h1C, 4'h1, 32'h01, rd);
        check("irq_w1c", irq, 1'b0);
        io_in = 8'h00;
        repeat (4) tick();
        check("irq_fall_masked", irq, 1'b0);
        access(32'h1C, 4'h0, 32'h0, rd);
        check("status_fall_masked", rd, 32'h0);

        // W1C lands on the same edge the new rising edge is detected
        io_in = 8'h01;
        tick();
        tick();
        access(32'h1C, 4'h1, 32'h01, rd);
        check("irq_set_wins", irq, IRQ_EN);
        access(32'h14, 4'h1, 32'h00, rd);
        check("irq_after_en_clr", irq, IRQ_EN);
        access(32'h1C, 4'h0, 32'h0, rd);
        check("status_set_wins", rd, IRQ_EN ? 32'h1 : 32'h0);
        access(32'h1C, 4'h1, 32'h01, rd);
        check("irq_final_clr", irq, 1'b0);
        io_in = 8'h00;
        repeat (4) tick();

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            bus.valid = ($urandom_range(0, 3) != 0);
            bus.addr  = $urandom;
            bus.wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0;
            bus.wdata = $urandom;
            if ($urandom_range(0, 3) == 0) io_in = io_in ^ W'($urandom);
            tick();
            check_model();
        end
        bus.valid = 1'b0;
        bus.wstrb = 4'b0;
        repeat (3) begin
            tick();
            check_model();
        end

        // Reset while an access is in flight
        access(32'h04, 4'h1, 32'hC3, rd);
        access(32'h00, 4'h1, 32'h5A, rd);
        bus.valid = 1'b1;
        bus.addr  = 32'h04;
        bus.wstrb = 4'h0;
        tick();
        #2 resetn = 1'b0;
        model_reset();
        #1;
        check("midrst_ready", bus.ready, 1'b0);
        check("midrst_rdata", bus.rdata, 32'h0);
        check("midrst_iosel", io_iosel, 8'h00);
        check("midrst_out", io_out, 8'h00);
        check("midrst_irq", irq, 1'b0);
        @(negedge clk);
        check("inrst_ready", bus.ready, 1'b0);
        bus.valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            tick();
            check("postrst_ready", bus.ready, 1'b0);
            check_model();
        end
        access(32'h00, 4'h0, 32'h0, rd);
        check("postrst_dir", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of GPIO pins, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, depth of the input synchroniser, legal range 2..4.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 valid  input  1  bus request.
REQ-006 ready  output  1  bus completion pulse.
REQ-007 wstrb  input  4  byte write enables; all zero means read.
REQ-008 addr  input  32  byte address; only addr[4:2] is decoded.
REQ-009 wdata  input  32  write data.
REQ-010 rdata  output  32  read data, valid while ready=1.
REQ-011 io_iosel  output  WIDTH  per-pin output enable (1 = drive).
REQ-012 io_out  output  WIDTH  per-pin output value.
REQ-013 io_in  input  WIDTH  raw asynchronous pin inputs.
REQ-014 irq  output  1  level interrupt request.

Function
REQ-015 An access SHALL be accepted on a cycle with valid=1 and ready=0; ready SHALL be 1 on the following cycle only, so back-to-back requests complete every second cycle.
REQ-016 Register writes and rdata capture SHALL occur on the accepting edge; rdata SHALL hold its value until the next accepted access.
REQ-017 A write SHALL update only the bits in bytes whose wstrb bit is 1; bits at or above WIDTH SHALL be ignored on write and read as 0.
REQ-018 Register map by addr[4:2]: 0 DIR (RW, drives io_iosel); 1 OUT (RW, drives io_out); 2 IN (RO, synchronised inputs); 3 OUT_SET (WO, 1 sets OUT bit, reads 0); 4 OUT_CLR (WO, 1 clears OUT bit, reads 0); 5 RISE_EN (RW); 6 FALL_EN (RW); 7 STATUS (RW1C).
REQ-019 Writes to IN SHALL be ignored; OUT_SET/OUT_CLR SHALL take effect on the accepting edge; io_out SHALL reflect the new value on the next cycle.
REQ-020 io_in SHALL pass through SYNC_STAGES flip-flops per bit; IN reads the last stage, so latency from pin to IN is SYNC_STAGES cycles.
REQ-021 A rising edge (previous synced 0, current synced 1) on bit n with RISE_EN[n]=1 SHALL set STATUS[n]; likewise falling edge with FALL_EN[n]=1.
REQ-022 When an edge set and a STATUS write-1-clear hit the same bit on the same edge, set SHALL win.
REQ-023 irq SHALL equal the OR of all STATUS bits, with no additional delay beyond the STATUS register.
REQ-024 Clearing RISE_EN/FALL_EN SHALL NOT clear already-set STATUS bits.

Reset
REQ-025 resetn=0 SHALL immediately clear ready, rdata, DIR, OUT, RISE_EN, FALL_EN, STATUS, all synchroniser stages and the edge-history register; io_iosel=0, io_out=0, irq=0.
REQ-026 An access in flight when reset asserts SHALL be dropped; no ready pulse SHALL follow reset release without a new valid.

Configuration
REQ-027 Macro GPIO_BANK_IRQ_EN: when defined, REQ-021..REQ-024 and registers 5-7 are implemented.
REQ-028 When GPIO_BANK_IRQ_EN is undefined, registers 5-7 SHALL read 0 and ignore writes, edge logic SHALL be absent, irq SHALL be tied 0; all other behaviour unchanged.

Verification
REQ-029 Write DIR=0xA5 wstrb=0001, read DIR -> io_iosel=0xA5 one cycle after accept, read returns 0x000000A5, ready pulses exactly one cycle per access.
REQ-030 OUT=0x0F, then OUT_SET=0xF0, then OUT_CLR=0x03 -> io_out sequence 0x0F, 0xFF, 0xFC; reads of addresses 3 and 4 return 0.
REQ-031 io_in bit 2 toggles 0->1 at cycle t -> IN read reflects 0x04 no earlier than t+2 with SYNC_STAGES=2.
REQ-032 RISE_EN=0x01, io_in[0] 0->1 -> STATUS=0x01 and irq=1; write STATUS=0x01 -> irq=0; falling edge with FALL_EN=0 -> STATUS stays 0.
REQ-033 STATUS[0] W1C on the same edge as a new enabled rising edge on bit 0 -> STATUS[0] remains 1, irq stays 1.
REQ-034 Assert resetn=0 mid-access with valid=1 -> all outputs 0 within the same cycle, no ready pulse after release until valid is re-asserted.
